// File: rtl/countdown_ctrl.sv
// countdown_ctrl
// Sequencing controller for an MM:SS countdown timer. Holds a four-digit BCD
// preset and the live count. Runs an IDLE/RUN/PAUSE/DONE state machine that is
// paced by a one-second prescaler, and presents the live digits to the display
// scanner.
//
// Ports
//   clk        system clock, all state updates on posedge
//   rst        synchronous active-high reset
//   btn_start  debounced single-cycle pulse, toggles run/pause
//   btn_clear  single-cycle pulse, back to IDLE with the preset reloaded
//   load       single-cycle pulse, captures preset_in (IDLE only)
//   preset_in  BCD {min_tens, min_ones, sec_tens, sec_ones}
//   num_out_0  seconds ones digit
//   num_out_1  seconds tens digit
//   num_out_2  minutes ones digit
//   num_out_3  minutes tens digit
//   running    high while in RUN
//   done       high while in DONE
//   blank      display blank request, blinks only in DONE
module countdown_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        load,
  input  logic [15:0] preset_in,
  output logic [3:0]  num_out_0,
  output logic [3:0]  num_out_1,
  output logic [3:0]  num_out_2,
  output logic [3:0]  num_out_3,
  output logic        running,
  output logic        done,
  output logic        blank
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Clamp one BCD digit to an upper bound.
  function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] max_v);
    logic [3:0] r;
    if (d > max_v) begin
      r = max_v;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Saturate a preset to a legal MM:SS value (max 99:59).
  function automatic logic [15:0] sat_preset(input logic [15:0] p);
    return {sat_digit(p[15:12], 4'd9), sat_digit(p[11:8], 4'd9),
            sat_digit(p[7:4], 4'd5), sat_digit(p[3:0], 4'd9)};
  endfunction

  // One-second BCD decrement with borrow; 00:00 is returned unchanged.
  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       b;
    d0 = c[3:0];
    d1 = c[7:4];
    d2 = c[11:8];
    d3 = c[15:12];
    b  = 1'b1;
    if (c == 16'h0000) begin
      b = 1'b0;
    end else begin
      if (d0 == 4'd0) begin
        d0 = 4'd9;
      end else begin
        d0 = d0 - 4'd1;
        b  = 1'b0;
      end
      if (b) begin
        if (d1 == 4'd0) begin
          d1 = 4'd5;
        end else begin
          d1 = d1 - 4'd1;
          b  = 1'b0;
        end
      end else begin
        d1 = d1;
      end
      if (b) begin
        if (d2 == 4'd0) begin
          d2 = 4'd9;
        end else begin
          d2 = d2 - 4'd1;
          b  = 1'b0;
        end
      end else begin
        d2 = d2;
      end
      // Non-zero count guarantees min_tens is non-zero if the borrow reaches it.
      if (b) begin
        d3 = d3 - 4'd1;
      end else begin
        d3 = d3;
      end
    end
    return {d3, d2, d1, d0};
  endfunction

  logic [1:0]    state_r;
  logic [15:0]   preset_r;
  logic [15:0]   count_r;
  logic [PW-1:0] presc_r;
  logic          blank_r;
  logic          running_r;
  logic          done_r;

  logic [1:0]    state_nxt_s;
  logic [15:0]   preset_nxt_s;
  logic [15:0]   count_nxt_s;
  logic [PW-1:0] presc_nxt_s;
  logic          blank_nxt_s;
  logic          tick_s;
  logic [15:0]   count_dec_s;

  assign tick_s      = (presc_r == TICK_MAX);
  assign count_dec_s = bcd_dec(count_r);

  // Next-state, count, preset and blank decisions; clear beats start everywhere.
  always_comb begin
    state_nxt_s  = state_r;
    preset_nxt_s = preset_r;
    count_nxt_s  = count_r;
    blank_nxt_s  = blank_r;
    case (state_r)
      ST_IDLE: begin
        blank_nxt_s = 1'b0;
        if (btn_clear) begin
          count_nxt_s = preset_r;
        end else if (load) begin
          // load wins over a coincident start
          preset_nxt_s = sat_preset(preset_in);
          count_nxt_s  = sat_preset(preset_in);
        end else if (btn_start && (count_r != 16'h0000)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (btn_clear) begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = preset_r;
        end else if (tick_s) begin
          count_nxt_s = count_dec_s;
          if (count_dec_s == 16'h0000) begin
            state_nxt_s = ST_DONE;
          end else if (btn_start) begin
            state_nxt_s = ST_PAUSE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else if (btn_start) begin
          state_nxt_s = ST_PAUSE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (btn_clear) begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = preset_r;
        end else if (btn_start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (btn_clear || btn_start) begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = preset_r;
          blank_nxt_s = 1'b0;
        end else if (tick_s) begin
          blank_nxt_s = ~blank_r;
        end else begin
          blank_nxt_s = blank_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        blank_nxt_s = 1'b0;
      end
    endcase
  end

  // Prescaler: free-runs in RUN/DONE, holds in PAUSE so a resume keeps the
  // partial second, and is zero whenever the machine is (or is going) IDLE.
  always_comb begin
    presc_nxt_s = presc_r;
    case (state_r)
      ST_RUN, ST_DONE: begin
        if (tick_s) begin
          presc_nxt_s = '0;
        end else begin
          presc_nxt_s = presc_r + PW'(1);
        end
      end
      ST_PAUSE: presc_nxt_s = presc_r;
      default:  presc_nxt_s = '0;
    endcase
    if (state_nxt_s == ST_IDLE) begin
      presc_nxt_s = '0;
    end else begin
      presc_nxt_s = presc_nxt_s;
    end
  end

  // State and output registers; flags follow the next state so they move on
  // the same edge as the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      preset_r  <= 16'h0000;
      count_r   <= 16'h0000;
      presc_r   <= '0;
      blank_r   <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      preset_r  <= preset_nxt_s;
      count_r   <= count_nxt_s;
      presc_r   <= presc_nxt_s;
      blank_r   <= blank_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
      done_r    <= (state_nxt_s == ST_DONE);
    end
  end

  assign num_out_0 = count_r[3:0];
  assign num_out_1 = count_r[7:4];
  assign num_out_2 = count_r[11:8];
  assign num_out_3 = count_r[15:12];
  assign running   = running_r;
  assign done      = done_r;
  assign blank     = blank_r;

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset_in = 16'h0000;
  logic [3:0]  num_out_0;
  logic [3:0]  num_out_1;
  logic [3:0]  num_out_2;
  logic [3:0]  num_out_3;
  logic        running;
  logic        done;
  logic        blank;

  int total = 0;
  int bad = 0;
  logic [18:0] exp_q[$];

  countdown_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
    .load(load), .preset_in(preset_in),
    .num_out_0(num_out_0), .num_out_1(num_out_1),
    .num_out_2(num_out_2), .num_out_3(num_out_3),
    .running(running), .done(done), .blank(blank)
  );

  always #5 clk = ~clk;

  // Expected observation word: {count, running, done, blank}
  function automatic logic [18:0] mk(input logic [15:0] c, input logic r, input logic d, input logic b);
    return {c, r, d, b};
  endfunction

  task automatic chk(input string tag);
    logic [18:0] got;
    logic [18:0] e;
    got = {num_out_3, num_out_2, num_out_1, num_out_0, running, done, blank};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, got=%h", tag, got);
    end else begin
      e = exp_q.pop_front();
      assert (got === e) else begin
        bad++;
        $error("FAIL %s: got=%h expected=%h", tag, got, e);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expected result, sample #1 after the edge.
  task automatic cyc(input logic r, input logic s, input logic c, input logic l,
                     input logic [15:0] p, input logic [18:0] e, input string tag);
    rst = r; btn_start = s; btn_clear = c; load = l; preset_in = p;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; load = 1'b0;
    chk(tag);
  endtask

  task automatic idle(input logic [18:0] e, input string tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, e, tag);
  endtask

  initial begin
    #2;
    // reset and load
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, mk(16'h0000, 1'b0, 1'b0, 1'b0), "reset0");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, mk(16'h0000, 1'b0, 1'b0, 1'b0), "reset1");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0105, mk(16'h0105, 1'b0, 1'b0, 1'b0), "load0105");

    // borrow chain 10:00 -> 09:59
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000, mk(16'h1000, 1'b0, 1'b0, 1'b0), "load1000");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h1000, 1'b1, 1'b0, 1'b0), "start1000");
    for (int i = 0; i < 3; i++) idle(mk(16'h1000, 1'b1, 1'b0, 1'b0), "pretick1000");
    idle(mk(16'h0959, 1'b1, 1'b0, 1'b0), "borrow0959");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, mk(16'h1000, 1'b0, 1'b0, 1'b0), "clear_reload");

    // 01:00 -> 00:59
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, mk(16'h0100, 1'b0, 1'b0, 1'b0), "load0100");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0100, 1'b1, 1'b0, 1'b0), "start0100");
    for (int i = 0; i < 3; i++) idle(mk(16'h0100, 1'b1, 1'b0, 1'b0), "pretick0100");
    idle(mk(16'h0059, 1'b1, 1'b0, 1'b0), "borrow0059");

    // load ignored in RUN, then saturation in IDLE
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'hFAFC, mk(16'h0059, 1'b1, 1'b0, 1'b0), "load_in_run");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, mk(16'h0100, 1'b0, 1'b0, 1'b0), "clear_0100");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'hFAFC, mk(16'h9959, 1'b0, 1'b0, 1'b0), "sat_count");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h9959, 1'b1, 1'b0, 1'b0), "start9959");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, mk(16'h9959, 1'b0, 1'b0, 1'b0), "sat_preset");

    // pause timing
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, mk(16'h0003, 1'b0, 1'b0, 1'b0), "load0003");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0003, 1'b1, 1'b0, 1'b0), "start0003");
    idle(mk(16'h0003, 1'b1, 1'b0, 1'b0), "run1");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0003, 1'b0, 1'b0, 1'b0), "pause");
    for (int i = 0; i < 20; i++) idle(mk(16'h0003, 1'b0, 1'b0, 1'b0), "paused_hold");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0003, 1'b1, 1'b0, 1'b0), "resume");
    idle(mk(16'h0003, 1'b1, 1'b0, 1'b0), "resume_run1");
    idle(mk(16'h0002, 1'b1, 1'b0, 1'b0), "resume_dec0002");

    // start coincident with tick: decrement then PAUSE
    for (int i = 0; i < 3; i++) idle(mk(16'h0002, 1'b1, 1'b0, 1'b0), "pretick0002");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0001, 1'b0, 1'b0, 1'b0), "start_on_tick");
    idle(mk(16'h0001, 1'b0, 1'b0, 1'b0), "paused_0001");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, mk(16'h0003, 1'b0, 1'b0, 1'b0), "clear_pause");

    // done and blink
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, mk(16'h0001, 1'b0, 1'b0, 1'b0), "load0001");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0001, 1'b1, 1'b0, 1'b0), "start0001");
    for (int i = 0; i < 3; i++) idle(mk(16'h0001, 1'b1, 1'b0, 1'b0), "pretick0001");
    idle(mk(16'h0000, 1'b0, 1'b1, 1'b0), "done_entry");
    for (int i = 0; i < 3; i++) idle(mk(16'h0000, 1'b0, 1'b1, 1'b0), "done_blank0a");
    for (int i = 0; i < 4; i++) idle(mk(16'h0000, 1'b0, 1'b1, 1'b1), "done_blank1a");
    for (int i = 0; i < 4; i++) idle(mk(16'h0000, 1'b0, 1'b1, 1'b0), "done_blank0b");
    idle(mk(16'h0000, 1'b0, 1'b1, 1'b1), "done_blank1b");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0001, 1'b0, 1'b0, 1'b0), "done_exit");

    // start at 00:00 stays in IDLE
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, mk(16'h0000, 1'b0, 1'b0, 1'b0), "load0000");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0000, 1'b0, 1'b0, 1'b0), "start_zero");
    idle(mk(16'h0000, 1'b0, 1'b0, 1'b0), "start_zero_hold");

    // clear beats start in RUN
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, mk(16'h0002, 1'b0, 1'b0, 1'b0), "load0002");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0002, 1'b1, 1'b0, 1'b0), "start0002");
    idle(mk(16'h0002, 1'b1, 1'b0, 1'b0), "run0002");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, mk(16'h0002, 1'b0, 1'b0, 1'b0), "clear_prio");
    for (int i = 0; i < 5; i++) idle(mk(16'h0002, 1'b0, 1'b0, 1'b0), "clear_prio_idle");

    // load beats start in IDLE
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0004, mk(16'h0004, 1'b0, 1'b0, 1'b0), "load_vs_start");
    idle(mk(16'h0004, 1'b0, 1'b0, 1'b0), "load_vs_start_hold");

    // reset mid-RUN loses the preset
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0004, 1'b1, 1'b0, 1'b0), "start0004");
    idle(mk(16'h0004, 1'b1, 1'b0, 1'b0), "run0004");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, mk(16'h0000, 1'b0, 1'b0, 1'b0), "rst_mid_run");
    for (int i = 0; i < 5; i++) idle(mk(16'h0000, 1'b0, 1'b0, 1'b0), "rst_idle");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, mk(16'h0000, 1'b0, 1'b0, 1'b0), "preset_lost");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, mk(16'h0000, 1'b0, 1'b0, 1'b0), "start_after_rst");

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the MM:SS countdown timer. Holds a four-digit BCD preset and the live count, and runs a run/pause/done state machine from a one-second prescaler. Drives the four digit inputs of the display scanner plus status flags. The scanner only displays what this block presents; all timing and digit arithmetic live here.

## Interface

- TICK_DIV, default 50_000_000: clk cycles per one-second tick; must be ≥ 2.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- btn_start  in  1  single-cycle pulse, already debounced; toggles run/pause.
- btn_clear  in  1  single-cycle pulse; returns to IDLE and reloads the preset.
- load  in  1  single-cycle pulse; captures preset_in (IDLE only).
- preset_in  in  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
- num_out_0  out  4  seconds ones digit to the scanner.
- num_out_1  out  4  seconds tens digit.
- num_out_2  out  4  minutes ones digit.
- num_out_3  out  4  minutes tens digit.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- blank  out  1  display blank request; blinks in DONE only.

## Operation

- States: IDLE, RUN, PAUSE, DONE.
- Registers: preset (16 b), count (4 BCD digits), prescaler (0..TICK_DIV-1), state, blank. All outputs are registered.
- Digit outputs are always the live count digits.
- Preset saturation on load: min_tens, min_ones and sec_ones values > 9 become 9; sec_tens > 5 becomes 5. The stored preset and count both take the saturated value. Maximum count is 99:59.
- Tick: prescaler == TICK_DIV-1. The prescaler then wraps to 0; otherwise it increments.
  - Counts in RUN and DONE.
  - Held in PAUSE, so resume keeps the partial second.
  - Forced to 0 in IDLE.
- Decrement is BCD with borrow:
  - sec_ones 0→9 borrows from sec_tens.
  - sec_tens 0→5 borrows from min_ones.
  - min_ones 0→9 borrows from min_tens.
- Transitions; btn_clear has priority over btn_start in every state:
  - IDLE:
    - load → preset and count ← sat(preset_in).
    - btn_start with count ≠ 0 → RUN.
    - btn_start with count == 0 → stay in IDLE.
    - load and btn_start in the same cycle: load wins, start is ignored.
  - RUN:
    - btn_clear → IDLE, count ← preset.
    - On a tick, count decrements. If the result is 00:00 → DONE; otherwise stay in RUN.
    - btn_start without tick → PAUSE.
    - btn_start with tick → decrement applied, then PAUSE (DONE if the result is 00:00).
  - PAUSE:
    - btn_start → RUN.
    - btn_clear → IDLE, count ← preset.
  - DONE:
    - btn_clear or btn_start → IDLE, count ← preset, blank ← 0.
    - Each tick toggles blank.
- load outside IDLE is ignored.
- Count never underflows: no decrement occurs at 00:00.

## Timing

- Reset, on the edge where rst is sampled high:
  - state = IDLE, preset = 0000, count = 0000.
  - prescaler = 0, running = 0, done = 0, blank = 0.
  - num_out_0..3 = 0.
- rst has priority over every other input.
- rst asserted mid-RUN aborts immediately; the stored preset is lost.
- Outputs change one edge after the causing input is sampled:
  - load → digits update next cycle.
  - btn_start → running = 1 next cycle.
- First decrement happens TICK_DIV cycles after the IDLE→RUN edge.
  - Prescaler starts at 0 on entry.
  - Tick occurs on the TICK_DIV-th RUN cycle.
- Pause/resume: total RUN cycles between successive decrements is always exactly TICK_DIV.
- done rises on the same edge the count reaches 0000. running falls on that same edge.
- In DONE:
  - blank first rises TICK_DIV cycles after entry.
  - blank then toggles every TICK_DIV cycles.
- Leaving DONE forces blank = 0 on the transition edge.
- The block does not depend on the scanner's clock; the scanner samples num_out_* asynchronously to its index.

## Test plan

- Reset/load (TICK_DIV=4): rst, then load preset_in=16'h0105 → num_out_3..0 = 0,1,0,5 next cycle; running=0; done=0.
- Borrow chain: load 16'h1000, start; after 4 cycles → 09:59. Load 16'h0100, run 1 tick → 00:59.
- Saturation: load 16'hFAFC → count and preset = 99:59. Load outside IDLE (RUN) → count unchanged.
- Pause timing: load 0003, start, pause after 2 RUN cycles, wait 20 cycles, resume → decrement to 0002 exactly 2 RUN cycles later. Start coincident with tick → 0001 and PAUSE.
- Done/blink: load 0001, start → done=1 and count 0000 on the 4th edge. blank toggles 1,0,1 every 4 cycles. btn_start → IDLE, count 0001, blank 0. Start at count 0000 in IDLE → stays IDLE.
- Priority/reset: clear+start in the same cycle in RUN → IDLE with count = preset. rst mid-RUN → all outputs 0, state IDLE.
